// File: rtl/my_pkg.sv
// Shared types and constants for the retire stage and its store queue.
package my_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    // Store access sizes carried with each queued store.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // One committed store waiting for the data-memory port.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
        logic [1:0]            size;
    } sq_entry_t;

endpackage

// File: rtl/retire_store_queue.sv
// In-order store queue: circular buffer of sq_entry_t with occupancy count.
// Head fields read as zero while the queue is empty.
module retire_store_queue
    import my_pkg::*;
#(
    parameter int unsigned SQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  sq_entry_t                 push_entry_i,
    input  logic                      pop_i,
    output sq_entry_t                 head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(SQ_DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(SQ_DEPTH);

    sq_entry_t           mem_q [SQ_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]       count_q, count_d;
    logic                do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(SQ_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Guards keep the pointers coherent even if a caller misbehaves.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next state; pointers wrap on power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

endmodule

// File: rtl/retire_multi.sv
// Retire stage: epoch-tag kill filter, 2-cycle register writeback, registered
// PC redirect and an in-order store queue draining over valid/ready.
// Optional macro RETIRE_STATS_EN adds retired/killed instruction counters.
// Store queue entries are DATA_W_DEF wide, so DATA_W must equal DATA_W_DEF.
module retire_multi
    import my_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 2,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned SQ_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_UNITS*DATA_W-1:0]  result,
    input  logic [$clog2(NUM_UNITS)-1:0] data_sel,
    input  logic [$clog2(NUM_UNITS)-1:0] addr_sel,
    input  logic                         in_valid,
    input  logic [TAG_W-1:0]             instruction_tag,
    input  logic                         we,
    input  logic                         jump,
    input  logic                         write_in,
    input  logic [1:0]                   size_in,
    output logic                         stall,
    output logic                         reg_we,
    output logic [DATA_W-1:0]            WrData,
    output logic                         pc_valid,
    output logic [DATA_W-1:0]            New_pc,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [DATA_W-1:0]            write_address,
    output logic [DATA_W-1:0]            DATA_out,
    output logic [1:0]                   size,
`ifdef RETIRE_STATS_EN
    output logic [31:0]                  retired_cnt,
    output logic [31:0]                  killed_cnt,
`endif
    output logic [$clog2(SQ_DEPTH):0]    sq_count
);

    logic [DATA_W-1:0] lane [NUM_UNITS];
    logic [DATA_W-1:0] data_lane, addr_lane;
    logic [TAG_W-1:0]  curr_tag_q, curr_tag_d;
    logic              killed, accept, live;
    logic              sq_full, sq_empty;
    sq_entry_t         sq_push_entry, sq_head;
    logic              wb1_we_q, wb1_we_d;
    logic [DATA_W-1:0] wb1_data_q, wb1_data_d;
    logic              reg_we_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              pc_valid_q, pc_valid_d;
    logic [DATA_W-1:0] new_pc_q, new_pc_d;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_lane
        assign lane[g] = result[g*DATA_W +: DATA_W];
    end

    assign data_lane = lane[data_sel];
    assign addr_lane = lane[addr_sel];

    assign killed = (instruction_tag != curr_tag_q);
    // Fullness is taken before any same-cycle pop.
    assign stall   = in_valid & write_in & sq_full;
    assign accept  = in_valid & ~stall;
    // Killed instructions are consumed but have no architectural effect.
    assign live    = accept & ~killed;

    // Next state for epoch tag, writeback stage 1 and redirect.
    always_comb begin
        curr_tag_d = curr_tag_q;
        pc_valid_d = 1'b0;
        new_pc_d   = new_pc_q;
        wb1_we_d   = live & we;
        wb1_data_d = (live & we) ? data_lane : '0;
        if (live & jump) begin
            curr_tag_d = curr_tag_q + 1'b1;
            pc_valid_d = 1'b1;
            new_pc_d   = addr_lane;
        end
    end

    // Tag, two-stage writeback pipeline and redirect registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curr_tag_q <= '0;
            wb1_we_q   <= 1'b0;
            wb1_data_q <= '0;
            reg_we_q   <= 1'b0;
            wr_data_q  <= '0;
            pc_valid_q <= 1'b0;
            new_pc_q   <= '0;
        end else begin
            curr_tag_q <= curr_tag_d;
            wb1_we_q   <= wb1_we_d;
            wb1_data_q <= wb1_data_d;
            reg_we_q   <= wb1_we_q;
            wr_data_q  <= wb1_data_q;
            pc_valid_q <= pc_valid_d;
            new_pc_q   <= new_pc_d;
        end
    end

    assign reg_we   = reg_we_q;
    assign WrData   = wr_data_q;
    assign pc_valid = pc_valid_q;
    assign New_pc   = new_pc_q;

    assign sq_push_entry = '{addr: addr_lane, data: data_lane, size: size_in};

    retire_store_queue #(
        .SQ_DEPTH (SQ_DEPTH)
    ) u_sq (
        .clk          (clk),
        .reset        (reset),
        .push_i       (live & write_in),
        .push_entry_i (sq_push_entry),
        .pop_i        (mem_valid & mem_ready),
        .head_o       (sq_head),
        .full_o       (sq_full),
        .empty_o      (sq_empty),
        .count_o      (sq_count)
    );

    assign mem_valid     = ~sq_empty;
    assign write_address = sq_head.addr;
    assign DATA_out      = sq_head.data;
    assign size          = sq_head.size;

`ifdef RETIRE_STATS_EN
    logic [31:0] retired_cnt_q, killed_cnt_q;

    // Wrapping counts of retired and killed accepted instructions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt_q <= '0;
            killed_cnt_q  <= '0;
        end else begin
            if (live)            retired_cnt_q <= retired_cnt_q + 1'b1;
            if (accept & killed) killed_cnt_q  <= killed_cnt_q + 1'b1;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign killed_cnt  = killed_cnt_q;
`endif

endmodule

// File: tb/tb_retire_multi.sv
// Self-checking bench for retire_multi: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue model.
module tb_retire_multi;
    import my_pkg::*;

    localparam int NUM_UNITS = 2;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 4;
    localparam int SQ_DEPTH  = 4;
    localparam int SEL_W     = $clog2(NUM_UNITS);

    logic                        clk = 1'b0;
    logic                        reset = 1'b0;
    logic [NUM_UNITS*DATA_W-1:0] result = '0;
    logic [SEL_W-1:0]            data_sel = '0, addr_sel = '0;
    logic                        in_valid = 1'b0, we = 1'b0, jump = 1'b0, write_in = 1'b0;
    logic [TAG_W-1:0]            instruction_tag = '0;
    logic [1:0]                  size_in = '0;
    logic                        mem_ready = 1'b0;
    logic                        stall, reg_we, pc_valid, mem_valid;
    logic [DATA_W-1:0]           WrData, New_pc, write_address, DATA_out;
    logic [1:0]                  size;
    logic [$clog2(SQ_DEPTH):0]   sq_count;
`ifdef RETIRE_STATS_EN
    logic [31:0]                 retired_cnt, killed_cnt;
`endif

    retire_multi #(
        .NUM_UNITS (NUM_UNITS),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .SQ_DEPTH  (SQ_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .result          (result),
        .data_sel        (data_sel),
        .addr_sel        (addr_sel),
        .in_valid        (in_valid),
        .instruction_tag (instruction_tag),
        .we              (we),
        .jump            (jump),
        .write_in        (write_in),
        .size_in         (size_in),
        .stall           (stall),
        .reg_we          (reg_we),
        .WrData          (WrData),
        .pc_valid        (pc_valid),
        .New_pc          (New_pc),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .write_address   (write_address),
        .DATA_out        (DATA_out),
        .size            (size),
`ifdef RETIRE_STATS_EN
        .retired_cnt     (retired_cnt),
        .killed_cnt      (killed_cnt),
`endif
        .sq_count        (sq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } ent_t;
    typedef struct {
        bit          we;
        logic [31:0] data;
    } wb_t;

    // Reference model state.
    ent_t        m_sq[$];
    wb_t         m_wb[$];
    int          m_tag;
    bit          m_pcv;
    logic [31:0] m_pc;
    int unsigned m_ret, m_kil;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return result[i*DATA_W +: DATA_W];
    endfunction

    task automatic model_reset();
        m_sq.delete();
        m_wb.delete();
        m_wb.push_back('{0, 32'h0});
        m_wb.push_back('{0, 32'h0});
        m_tag = 0;
        m_pcv = 0;
        m_pc  = '0;
        m_ret = 0;
        m_kil = 0;
    endtask

    // Compare every DUT output with the model for the current cycle.
    task automatic compare_all();
        bit exp_stall;
        exp_stall = in_valid && write_in && (m_sq.size() == SQ_DEPTH);
        check("stall", stall, exp_stall);
        check("reg_we", reg_we, m_wb[0].we);
        if (m_wb[0].we) check("WrData", WrData, m_wb[0].data);
        check("pc_valid", pc_valid, m_pcv);
        check("New_pc", New_pc, m_pc);
        check("mem_valid", mem_valid, m_sq.size() != 0);
        check("sq_count", sq_count, m_sq.size());
        if (m_sq.size() != 0) begin
            check("write_address", write_address, m_sq[0].addr);
            check("DATA_out", DATA_out, m_sq[0].data);
            check("size", size, m_sq[0].size);
        end else begin
            check("write_address_empty", write_address, 0);
            check("DATA_out_empty", DATA_out, 0);
            check("size_empty", size, 0);
        end
`ifdef RETIRE_STATS_EN
        check("retired_cnt", retired_cnt, m_ret);
        check("killed_cnt", killed_cnt, m_kil);
`endif
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        bit   acc, kil, live;
        ent_t e;
        acc  = in_valid && !(write_in && m_sq.size() == SQ_DEPTH);
        kil  = (int'(instruction_tag) != m_tag);
        live = acc && !kil;
        m_wb.push_back('{live && we, lane(int'(data_sel))});
        void'(m_wb.pop_front());
        m_pcv = live && jump;
        if (live && jump) begin
            m_pc  = lane(int'(addr_sel));
            m_tag = (m_tag + 1) % (1 << TAG_W);
        end
        if (m_sq.size() != 0 && mem_ready) void'(m_sq.pop_front());
        if (live && write_in) begin
            e.addr = lane(int'(addr_sel));
            e.data = lane(int'(data_sel));
            e.size = size_in;
            m_sq.push_back(e);
        end
        if (live) m_ret++;
        if (acc && kil) m_kil++;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; we = 0; jump = 0; write_in = 0; mem_ready = 0;
        instruction_tag = '0; size_in = '0; data_sel = '0; addr_sel = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic present(input int tag, input bit w, input bit j, input bit st,
                           input logic [31:0] l0, input logic [31:0] l1,
                           input int dsel, input int asel, input logic [1:0] sz);
        in_valid = 1; instruction_tag = TAG_W'(tag);
        we = w; jump = j; write_in = st;
        result[0 +: DATA_W] = l0;
        result[DATA_W +: DATA_W] = l1;
        data_sel = SEL_W'(dsel); addr_sel = SEL_W'(asel); size_in = sz;
    endtask

    task automatic drive_random();
        in_valid = ($urandom_range(3) != 0);
        instruction_tag = ($urandom_range(3) != 0) ? TAG_W'(m_tag) : TAG_W'($urandom);
        we       = $urandom_range(1);
        jump     = ($urandom_range(3) == 0);
        write_in = $urandom_range(1);
        size_in  = 2'($urandom_range(2));
        for (int i = 0; i < NUM_UNITS; i++) result[i*DATA_W +: DATA_W] = $urandom;
        data_sel  = SEL_W'($urandom_range(NUM_UNITS - 1));
        addr_sel  = SEL_W'($urandom_range(NUM_UNITS - 1));
        mem_ready = $urandom_range(1);
    endtask

    initial begin
        model_reset();
        apply_reset();

        // Reset state.
        check("rst_reg_we", reg_we, 0);
        check("rst_pc_valid", pc_valid, 0);
        check("rst_New_pc", New_pc, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_sq_count", sq_count, 0);

        // Writeback appears exactly two cycles after acceptance.
        present(0, 1, 0, 0, 32'hA5, 32'h0, 0, 0, SIZE_BYTE);
        cycle();
        idle_inputs();
        check("wb_n1_reg_we", reg_we, 0);
        cycle();
        check("wb_n2_reg_we", reg_we, 1);
        check("wb_n2_WrData", WrData, 32'hA5);

        // Jump redirects, bumps the tag, and kills the stale-tag follower.
        present(0, 0, 1, 0, 32'h0, 32'h100, 0, 1, SIZE_BYTE);
        cycle();
        check("jmp_pc_valid", pc_valid, 1);
        check("jmp_New_pc", New_pc, 32'h100);
        present(0, 1, 0, 0, 32'h33, 32'h0, 0, 0, SIZE_BYTE);
        cycle();
        check("jmp_pc_pulse_end", pc_valid, 0);
        check("jmp_New_pc_hold", New_pc, 32'h100);
        present(1, 1, 0, 0, 32'h77, 32'h0, 0, 0, SIZE_BYTE);
        cycle();
        idle_inputs();
        check("killed_no_reg_we", reg_we, 0);
        cycle();
        check("tag1_reg_we", reg_we, 1);
        check("tag1_WrData", WrData, 32'h77);

        // Sixteen jumps wrap the 4-bit tag back to 0.
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            present(i, 0, 1, 0, 32'h0, 32'h200 + i, 0, 1, SIZE_BYTE);
            cycle();
        end
        present(0, 1, 0, 0, 32'h5A, 32'h0, 0, 0, SIZE_BYTE);
        cycle();
        idle_inputs();
        cycle();
        check("wrap_reg_we", reg_we, 1);
        check("wrap_WrData", WrData, 32'h5A);

        // Fill the queue, then a fifth store stalls until a pop frees a slot.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            present(0, 0, 0, 1, 32'h2000 + i, 32'h1000 + i, 0, 1, 2'(i % 3));
            cycle();
        end
        check("full_sq_count", sq_count, 4);
        present(0, 0, 0, 1, 32'h2004, 32'h1004, 0, 1, SIZE_WORD);
        #1;
        check("full_stall", stall, 1);
        mem_ready = 1;
        cycle();
        check("full_pop_stall_held_count", sq_count, 3);
        mem_ready = 0;
        #1;
        check("full_after_pop_stall", stall, 0);
        cycle();
        check("fifth_accepted_count", sq_count, 4);
        idle_inputs();
        mem_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_addr", write_address, 32'h1000 + i);
            check("drain_data", DATA_out, 32'h2000 + i);
            cycle();
        end
        check("drained_mem_valid", mem_valid, 0);

        // Simultaneous push and pop at count 2, then async reset mid-drain.
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            present(0, 0, 0, 1, 32'h3000 + i, 32'h4000 + i, 0, 1, SIZE_HALF);
            cycle();
        end
        present(0, 0, 0, 1, 32'h3002, 32'h4002, 0, 1, SIZE_HALF);
        mem_ready = 1;
        cycle();
        check("pushpop_count", sq_count, 2);
        in_valid = 0;
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_mem_valid", mem_valid, 0);
        check("async_rst_sq_count", sq_count, 0);
        apply_reset();

`ifdef RETIRE_STATS_EN
        // Three retired and two killed instructions.
        apply_reset();
        present(0, 0, 0, 0, 32'h1, 32'h0, 0, 0, SIZE_BYTE); cycle();
        present(5, 0, 0, 0, 32'h1, 32'h0, 0, 0, SIZE_BYTE); cycle();
        present(0, 1, 0, 0, 32'h1, 32'h0, 0, 0, SIZE_BYTE); cycle();
        present(7, 1, 0, 0, 32'h1, 32'h0, 0, 0, SIZE_BYTE); cycle();
        present(0, 0, 0, 0, 32'h1, 32'h0, 0, 0, SIZE_BYTE); cycle();
        idle_inputs();
        check("stats_retired", retired_cnt, 3);
        check("stats_killed", killed_cnt, 2);
`endif

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
